uart_tx_arbiter: RTL and testbench

- Shares one `uart` transmit byte stream (i_data/i_valid/o_ready side) between N requesters. Each requester sends packets of bytes delimited by a last flag.
- Round-robin arbitration with packet lock: once a requester is granted, it keeps the grant until its last byte, or until the optional length cap forces release.
- Sits between firmware/peripheral byte sources and the `uart` instance. Its o_data/o_valid/i_ready connect directly to uart i_data/i_valid/o_ready.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rr_pick.sv | 43 ++++
 rtl/uart_tx_arbiter.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter slice.
//   UART_DATA_W  : width of one byte lane to the uart
//   UART_HDR_TAG : upper nibble of the requester-ID header byte
//   state_t      : arbiter FSM state encoding (ST_IDLE, ST_HDR, ST_XFER)
// ST_HDR is only reachable when UART_TX_ARB_ID_HDR_EN is defined.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int         UART_DATA_W  = 8;
    localparam logic [3:0] UART_HDR_TAG = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// ---------------------------------------------------------------------------
// uart_rr_pick
// Combinational round-robin selector. Scans req upward starting at ptr,
// wrapping from N-1 back to 0, and returns the first requester found.
// Ports:
//   req   [N]     : request vector
//   ptr   [IDX_W] : index with highest priority this round
//   gnt   [N]     : one-hot selected requester (0 when none)
//   index [IDX_W] : binary index of the selected requester
//   any           : at least one request is present
// ---------------------------------------------------------------------------
module uart_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    always_comb begin
        int k;
        gnt   = '0;
        index = '0;
        any   = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            // Candidate position i steps after ptr, folded back into 0..N-1.
            k = int'(ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!any && req[k]) begin
                any    = 1'b1;
                gnt[k] = 1'b1;
                index  = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart transmit byte stream between N requesters using
// round-robin arbitration with packet lock. A grant is held until the
// owner's last byte, or until MAX_LEN beats when MAX_LEN != 0 (o_trunc
// pulses for that release).
//
// Optional feature: define UART_TX_ARB_ID_HDR_EN to emit a header byte
// {4'hA, grant index} ahead of each granted packet.
//
// Handshake: a byte moves on any edge where valid and ready are both high.
// valid never waits for ready; ready may depend on valid. In ST_XFER the
// owner's lane is passed straight through combinationally.
//
// Ports:
//   i_clk, i_rst : clock, synchronous active-low reset
//   i_data       : N byte lanes, requester k on [8k+7:8k]
//   i_valid      : per-requester byte valid
//   i_last       : per-requester final byte of packet
//   o_ready      : per-requester byte accepted (only the owner's bit)
//   o_data       : byte to uart
//   o_valid      : byte valid to uart
//   i_ready      : uart ready
//   o_grant      : one-hot owner, 0 when idle
//   o_busy       : FSM not in ST_IDLE
//   o_trunc      : one-cycle pulse after a cap-forced release
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_LEN  = 0,
    parameter int LEN_BITS = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [N*UART_DATA_W-1:0] i_data,
    input  logic [N-1:0]             i_valid,
    input  logic [N-1:0]             i_last,
    output logic [N-1:0]             o_ready,
    output logic [UART_DATA_W-1:0]   o_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [N-1:0]             o_grant,
    output logic                     o_busy,
    output logic                     o_trunc
);

    localparam int                IDX_W = $clog2(N);
    localparam logic [LEN_BITS:0] CAP   = (LEN_BITS+1)'(MAX_LEN);

    state_t               state;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     owner;
    logic [LEN_BITS-1:0]  count;

    logic [N-1:0]         pick_gnt;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;

    logic [UART_DATA_W-1:0] req_byte [N];
    logic [UART_DATA_W-1:0] sel_byte;
    logic                   sel_valid;
    logic                   sel_last;
    logic                   beat;
    logic [LEN_BITS:0]      count_inc;
    logic                   cap_hit;
    logic [IDX_W-1:0]       next_ptr;

    uart_rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (i_valid),
        .ptr   (ptr),
        .gnt   (pick_gnt),
        .index (pick_idx),
        .any   (pick_any)
    );

    for (genvar k = 0; k < N; k++) begin : g_lane
        assign req_byte[k] = i_data[k*UART_DATA_W +: UART_DATA_W];
    end

    assign sel_byte  = req_byte[owner];
    assign sel_valid = i_valid[owner];
    assign sel_last  = i_last[owner];
    assign beat      = (state == ST_XFER) && sel_valid && i_ready;

    // Cap is checked against the count including the current beat.
    assign count_inc = {1'b0, count} + (LEN_BITS+1)'(1);
    assign cap_hit   = (MAX_LEN != 0) && (count_inc == CAP);
    assign next_ptr  = (owner == IDX_W'(N-1)) ? '0 : owner + 1'b1;

    assign o_busy = (state != ST_IDLE);

    always_comb begin
        o_data  = '0;
        o_valid = 1'b0;
        o_ready = '0;
        case (state)
            ST_XFER: begin
                o_data  = sel_byte;
                o_valid = sel_valid;
                o_ready = o_grant & {N{i_ready}};
            end
`ifdef UART_TX_ARB_ID_HDR_EN
            ST_HDR: begin
                o_data  = {UART_HDR_TAG, 4'(owner)};
                o_valid = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            owner   <= '0;
            count   <= '0;
            o_grant <= '0;
            o_trunc <= 1'b0;
        end else begin
            o_trunc <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        owner   <= pick_idx;
                        o_grant <= pick_gnt;
                        count   <= '0;
`ifdef UART_TX_ARB_ID_HDR_EN
                        state   <= ST_HDR;
`else
                        state   <= ST_XFER;
`endif
                    end
                end
`ifdef UART_TX_ARB_ID_HDR_EN
                ST_HDR: begin
                    if (i_ready) begin
                        state <= ST_XFER;
                    end
                end
`endif
                ST_XFER: begin
                    if (beat) begin
                        if (sel_last || cap_hit) begin
                            state   <= ST_IDLE;
                            ptr     <= next_ptr;
                            count   <= '0;
                            o_grant <= '0;
                            // A last byte that also hits the cap is a normal end.
                            o_trunc <= cap_hit && !sel_last;
                        end else if (count != '1) begin
                            count <= count + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Bench for uart_tx_arbiter with N=4, MAX_LEN=4. Directed cycle table,
// hand-written reset / header sequences, and packet-level reference model
// (per-requester byte lists, round-robin over non-empty lists) driving
// fixed and randomized traffic.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N        = 4;
    localparam int MAX_LEN  = 4;
    localparam int LEN_BITS = 8;
    localparam int DEPTH    = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   data = '0;
    logic [N-1:0]  valid = '0;
    logic [N-1:0]  last = '0;
    logic          ready = 1'b0;
    logic [N-1:0]  o_ready;
    logic [7:0]    o_data;
    logic          o_valid;
    logic [N-1:0]  o_grant;
    logic          o_busy;
    logic          o_trunc;

    int errors = 0;
    int checks = 0;

    // Source byte lists: bit 8 = last flag, bits 7:0 = byte.
    logic [8:0]  src_mem [N][DEPTH];
    int          src_len [N];
    int          head    [N];

    // Expected stream entry: [13]=header, [12]=trunc after it, [11:8]=owner, [7:0]=byte.
    logic [13:0] exp_q[$];
    int          exp_trunc;
    int          exp_cycles;
    bit          tr_pend;
    int          tr_seen;

    uart_tx_arbiter #(
        .N        (N),
        .MAX_LEN  (MAX_LEN),
        .LEN_BITS (LEN_BITS)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst_n),
        .i_data  (data),
        .i_valid (valid),
        .i_last  (last),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (ready),
        .o_grant (o_grant),
        .o_busy  (o_busy),
        .o_trunc (o_trunc)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        valid = '0;
        last  = '0;
        data  = '0;
        ready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // ---------------- reference model ----------------
    task automatic build_model();
        int  h [N];
        int  p, g, k, cnt;
        bit  more, done;
        logic [8:0] s;
        exp_q.delete();
        exp_trunc  = 0;
        exp_cycles = 0;
        p = 0;
        for (int i = 0; i < N; i++) h[i] = 0;
        more = 1'b1;
        while (more) begin
            g = -1;
            for (int i = 0; i < N; i++) begin
                k = (p + i) % N;
                if (g < 0 && h[k] < src_len[k]) g = k;
            end
            if (g < 0) begin
                more = 1'b0;
            end else begin
                exp_cycles++;
`ifdef UART_TX_ARB_ID_HDR_EN
                exp_q.push_back({1'b1, 1'b0, 4'(g), 4'hA, 4'(g)});
                exp_cycles++;
`endif
                cnt  = 0;
                done = 1'b0;
                while (!done) begin
                    s = src_mem[g][h[g]];
                    h[g]++;
                    cnt++;
                    exp_cycles++;
                    if (s[8]) begin
                        exp_q.push_back({1'b0, 1'b0, 4'(g), s[7:0]});
                        done = 1'b1;
                    end else if (MAX_LEN != 0 && cnt == MAX_LEN) begin
                        exp_q.push_back({1'b0, 1'b1, 4'(g), s[7:0]});
                        exp_trunc++;
                        done = 1'b1;
                    end else begin
                        exp_q.push_back({1'b0, 1'b0, 4'(g), s[7:0]});
                    end
                end
                p = (g + 1) % N;
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic clear_src();
        for (int k = 0; k < N; k++) begin
            src_len[k] = 0;
            head[k]    = 0;
        end
    endtask

    task automatic add_packet(input int k, input int len, input logic [7:0] first);
        for (int b = 0; b < len; b++) begin
            src_mem[k][src_len[k]] = {(b == len - 1), first + 8'(b)};
            src_len[k]++;
        end
    endtask

    task automatic fill_random(input int maxpk);
        int npk, len;
        clear_src();
        for (int k = 0; k < N; k++) begin
            npk = $urandom_range(0, maxpk);
            for (int p = 0; p < npk; p++) begin
                len = $urandom_range(1, 6);
                for (int b = 0; b < len; b++) begin
                    src_mem[k][src_len[k]] = {(b == len - 1), 8'($urandom)};
                    src_len[k]++;
                end
            end
        end
    endtask

    task automatic drive_heads(input bit rnd);
        for (int k = 0; k < N; k++) begin
            if (head[k] < src_len[k]) begin
                valid[k]        = 1'b1;
                last[k]         = src_mem[k][head[k]][8];
                data[k*8 +: 8]  = src_mem[k][head[k]][7:0];
            end else begin
                valid[k]        = 1'b0;
                last[k]         = 1'b0;
                data[k*8 +: 8]  = 8'h00;
            end
        end
        ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic sample_cycle(input string tag);
        logic [13:0] e;
        if (tr_pend || o_trunc) chk({tag, "_trunc_pulse"}, 32'(o_trunc), 32'(tr_pend));
        if (o_trunc) tr_seen++;
        tr_pend = 1'b0;
        if (o_valid && ready) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_extra_byte"}, 32'(o_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk({tag, "_data"},  32'(o_data),  32'(e[7:0]));
                chk({tag, "_grant"}, 32'(o_grant), 32'(1) << e[11:8]);
                chk({tag, "_ready"}, 32'(o_ready), e[13] ? 32'd0 : (32'(1) << e[11:8]));
                tr_pend = e[12];
            end
        end
        for (int k = 0; k < N; k++) begin
            if (valid[k] && o_ready[k]) head[k]++;
        end
    endtask

    task automatic run_engine(input string tag, input bit rnd);
        int cyc, budget;
        build_model();
        budget  = 20 * exp_q.size() + 50;
        cyc     = 0;
        tr_pend = 1'b0;
        tr_seen = 0;
        while (exp_q.size() != 0 && cyc < budget) begin
            drive_heads(rnd);
            @(negedge clk);
            sample_cycle(tag);
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_left_over"}, 32'(exp_q.size()), 32'd0);
        if (!rnd) chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cycles));
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sample_cycle(tag);
            @(posedge clk); #1;
        end
        chk({tag, "_trunc_count"}, 32'(tr_seen), 32'(exp_trunc));
        chk({tag, "_idle_after"}, {29'd0, o_busy, o_valid, |o_grant}, 32'd0);
    endtask

    // ---------------- directed table ----------------
    typedef struct packed {
        logic [3:0]  v;
        logic [3:0]  l;
        logic [31:0] d;
        logic        r;
        logic [3:0]  eg;
        logic        ev;
        logic [7:0]  ed;
        logic [3:0]  er;
        logic        eb;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int got, beats;

        // Reset state with every requester shouting.
        rst_n = 1'b0;
        valid = '1;
        last  = '0;
        data  = 32'hDEAD_BEEF;
        ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_grant", 32'(o_grant), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_busy",  32'(o_busy),  32'd0);
        chk("rst_trunc", 32'(o_trunc), 32'd0);
        chk("rst_data",  32'(o_data),  32'd0);
        do_reset();

`ifndef UART_TX_ARB_ID_HDR_EN
        // Requester 1: 0x11,0x22,0x33 with backpressure, then ptr=2 check.
        tbl[0]  = '{4'b0010, 4'b0000, 32'h0000_1100, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
        tbl[1]  = '{4'b0010, 4'b0000, 32'h0000_1100, 1'b1, 4'b0010, 1'b1, 8'h11, 4'b0010, 1'b1};
        tbl[2]  = '{4'b0010, 4'b0000, 32'h0000_2200, 1'b1, 4'b0010, 1'b1, 8'h22, 4'b0010, 1'b1};
        tbl[3]  = '{4'b0010, 4'b0010, 32'h0000_3300, 1'b0, 4'b0010, 1'b1, 8'h33, 4'b0000, 1'b1};
        tbl[4]  = '{4'b0010, 4'b0010, 32'h0000_3300, 1'b0, 4'b0010, 1'b1, 8'h33, 4'b0000, 1'b1};
        tbl[5]  = '{4'b0010, 4'b0010, 32'h0000_3300, 1'b1, 4'b0010, 1'b1, 8'h33, 4'b0010, 1'b1};
        tbl[6]  = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
        tbl[7]  = '{4'b0110, 4'b0110, 32'h0044_5500, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
        tbl[8]  = '{4'b0110, 4'b0110, 32'h0044_5500, 1'b1, 4'b0100, 1'b1, 8'h44, 4'b0100, 1'b1};
        tbl[9]  = '{4'b0010, 4'b0010, 32'h0000_5500, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
        tbl[10] = '{4'b0010, 4'b0010, 32'h0000_5500, 1'b1, 4'b0010, 1'b1, 8'h55, 4'b0010, 1'b1};
        tbl[11] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
        for (int i = 0; i < 12; i++) begin
            valid = tbl[i].v;
            last  = tbl[i].l;
            data  = tbl[i].d;
            ready = tbl[i].r;
            @(negedge clk);
            chk($sformatf("tbl%0d_grant", i), 32'(o_grant), 32'(tbl[i].eg));
            chk($sformatf("tbl%0d_valid", i), 32'(o_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), 32'(o_data), 32'(tbl[i].ed));
            chk($sformatf("tbl%0d_ready", i), 32'(o_ready), 32'(tbl[i].er));
            chk($sformatf("tbl%0d_busy", i),  32'(o_busy),  32'(tbl[i].eb));
            @(posedge clk); #1;
        end
`else
        // Requester 3 sends 0x5A: header 0xA3 first, o_ready low during it.
        valid = 4'b1000;
        last  = 4'b1000;
        data  = 32'h5A00_0000;
        ready = 1'b1;
        @(negedge clk);
        chk("hdr_idle_valid", 32'(o_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hdr_byte",  32'(o_data),  32'h0000_00A3);
        chk("hdr_valid", 32'(o_valid), 32'd1);
        chk("hdr_ready", 32'(o_ready), 32'd0);
        chk("hdr_grant", 32'(o_grant), 32'b1000);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hdr_payload", 32'(o_data),  32'h0000_005A);
        chk("hdr_pay_rdy", 32'(o_ready), 32'b1000);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("hdr_done_busy", 32'(o_busy), 32'd0);
        @(posedge clk); #1;
`endif

        // Reset mid-packet: move ptr to 3 first so the reset of ptr is visible.
        do_reset();
        valid = 4'b0100;
        last  = 4'b0100;
        data  = 32'h0077_0000;
        ready = 1'b1;
        got   = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            @(negedge clk);
            if (valid[2] && o_ready[2]) got = 1;
            @(posedge clk); #1;
        end
        chk("rst_pre_packet", 32'(got), 32'd1);
        idle_inputs();
        valid = 4'b0001;
        data  = 32'h0000_0010;
        beats = 0;
        for (int c = 0; c < 10 && beats == 0; c++) begin
            @(negedge clk);
            if (valid[0] && o_ready[0]) beats++;
            @(posedge clk); #1;
        end
        chk("rst_first_beat", 32'(beats), 32'd1);
        data  = 32'h0000_0020;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        valid = 4'b1001;
        data  = 32'h3300_0010;
        @(negedge clk);
        chk("rst_mid_valid", 32'(o_valid), 32'd0);
        chk("rst_mid_grant", 32'(o_grant), 32'd0);
        chk("rst_mid_busy",  32'(o_busy),  32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_ptr0", 32'(o_grant), 32'b0001);
        @(posedge clk); #1;

        // Four requesters, one 2-byte packet each, ready held high.
        do_reset();
        clear_src();
        for (int k = 0; k < N; k++) add_packet(k, 2, 8'(k * 16 + 1));
        run_engine("rr4", 1'b0);

        // Cap: requester 0 has 6 bytes, requester 2 has 2 bytes.
        do_reset();
        clear_src();
        add_packet(0, 6, 8'h01);
        add_packet(2, 2, 8'h21);
        run_engine("cap", 1'b0);

        // Randomized traffic with random uart backpressure.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            fill_random(3);
            run_engine($sformatf("rnd%0d", r), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
